multicycle_processor: RTL and testbench

MULTICYCLE_PROCESSOR -- requirements
Module: multicycle_processor

---
 rtl/processor_pkg.sv | 36 +++
 rtl/sp_ram.sv | 23 ++
 rtl/multicycle_processor.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_processor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the multicycle processor.
// Opcodes, FSM states and instruction field positions.
package processor_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LW   = 4'd1,
    OP_SW   = 4'd2,
    OP_BEQ  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_ADDI = 4'd8
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 23;
  localparam int RS1_HI = 22;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 13;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/sp_ram.sv
// Single-port data memory with synchronous read.
// Contents are intentionally not reset.
module sp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write-first is not needed: read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle processor: FETCH/DECODE/EXEC/MEM/WB.
// Register file and ALU local, data memory in sp_ram.
module multicycle_processor
  import processor_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [15:0]       pc,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int RI_W   = (NREGS > 1) ? $clog2(NREGS) : 1;

  function automatic logic [RI_W-1:0] ridx(
    input logic [4:0] f
  );
    int v;
    v = int'(f) % NREGS;
    return v[RI_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [15:0]       pc_q, pc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] alu;

  logic [3:0]        op;
  logic [RI_W-1:0]   rd_i, rs1_i, rs2_i;
  logic [15:0]       imm;
  logic [DATA_W-1:0] sext, rd_v, rs1_v, rs2_v;
  logic [DATA_W-1:0] ea;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       pc_inc;
  logic              is_mem, is_alu;
  logic              is_beq, is_nop;

  assign op     = ir_q[OP_HI:OP_LO];
  assign rd_i   = ridx(ir_q[RD_HI:RD_LO]);
  assign rs1_i  = ridx(ir_q[RS1_HI:RS1_LO]);
  assign rs2_i  = ridx(ir_q[RS2_HI:RS2_LO]);
  assign imm    = ir_q[IMM_HI:IMM_LO];
  assign sext   = {{(DATA_W-16){imm[15]}}, imm};
  assign rd_v   = regs_q[rd_i];
  assign rs1_v  = regs_q[rs1_i];
  assign rs2_v  = regs_q[rs2_i];
  assign ea     = rs1_v + sext;
  assign mem_addr = ea[ADDR_W-1:0];
  assign pc_inc = pc_q + 16'd1;

  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_alu = op inside {OP_ADD, OP_SUB, OP_AND,
                             OP_OR, OP_ADDI};
  assign is_beq = (op == OP_BEQ);
  assign is_nop = (op == OP_NOP);

  assign inst_ready   = rst_n && (state_q == S_FETCH);
  assign result_valid = (state_q == S_WB);
  assign pc           = pc_q;
  assign result       = result_q;

  sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (rd_v),
    .rdata (mem_rdata)
  );

  // ALU for register and immediate forms.
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = rs1_v + rs2_v;
      OP_SUB:  alu = rs1_v - rs2_v;
      OP_AND:  alu = rs1_v & rs2_v;
      OP_OR:   alu = rs1_v | rs2_v;
      OP_ADDI: alu = rs1_v + sext;
      default: alu = '0;
    endcase
  end

  // Next state, writeback, store enable and pc update.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    result_d = result_q;
    wr_en    = 1'b0;
    mem_we   = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (inst_ready && inst_valid) begin
          ir_d    = inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_mem: state_d = S_MEM;
          is_alu: begin
            state_d  = S_WB;
            result_d = alu;
            wr_en    = 1'b1;
          end
          is_beq: begin
            state_d = S_FETCH;
            pc_d    = (rd_v == rs1_v) ?
                      pc_q + imm : pc_inc;
          end
          is_nop: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
            pc_d    = pc_inc;
          end
        endcase
      end
      S_MEM: begin
        if (op == OP_LW) begin
          state_d  = S_WB;
          result_d = mem_rdata;
          wr_en    = 1'b1;
        end else begin
          mem_we  = 1'b1;
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Control and architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      pc_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      result_q <= result_d;
    end
  end

  // Register file; r0 writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wr_en && (rd_i != '0)) begin
      regs_q[rd_i] <= result_d;
    end
  end

endmodule

// File: tb/tb_multicycle_processor.sv
// Randomized self-checking bench for multicycle_processor.
// Behavioural model predicts per-cycle outputs.
module tb_multicycle_processor;

  localparam int NR = 32;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] pc;
  logic [31:0] result;
  logic        result_valid;
  logic        illegal;

  multicycle_processor #(
    .DATA_W    (32),
    .NREGS     (NR),
    .MEM_DEPTH (256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .pc           (pc),
    .result       (result),
    .result_valid (result_valid),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk     = 1'b0;

  logic [31:0] rf [NR];
  logic [31:0] mm [bit [7:0]];
  logic [15:0] pc_old, pc_new;
  logic [31:0] res_old, res_new;
  int acc_c = -10;
  int rdy_c = 0;
  int rv_c  = -1;
  int ill_c = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk) begin
      check($sformatf("ready@%0d", cyc),
            {31'd0, inst_ready},
            {31'd0, (cyc <= acc_c) || (cyc >= rdy_c)});
      check($sformatf("rvalid@%0d", cyc),
            {31'd0, result_valid},
            {31'd0, cyc == rv_c});
      check($sformatf("illegal@%0d", cyc),
            {31'd0, illegal},
            {31'd0, cyc == ill_c});
      check($sformatf("result@%0d", cyc), result,
            (cyc >= rv_c) ? res_new : res_old);
      check($sformatf("pc@%0d", cyc), {16'd0, pc},
            {16'd0, (cyc >= rdy_c) ? pc_new : pc_old});
    end
  end

  function automatic logic [31:0] ri(
    input logic [3:0] op, input int rd,
    input int rs1, input logic [15:0] im);
    return {op, 5'(rd), 5'(rs1), 2'b00, im};
  endfunction

  function automatic logic [31:0] rr(
    input logic [3:0] op, input int rd,
    input int rs1, input int rs2);
    return {op, 5'(rd), 5'(rs1), 5'(rs2), 13'd0};
  endfunction

  function automatic logic [7:0] eaddr(
    input logic [31:0] w);
    logic [31:0] ea;
    ea = rf[int'(w[22:18]) % NR]
       + {{16{w[15]}}, w[15:0]};
    return ea[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) rf[i] = '0;
    pc_old = '0;  pc_new = '0;
    res_old = '0; res_new = '0;
    acc_c = -10; rdy_c = 0;
    rv_c = -1;   ill_c = -1;
  endtask

  // Called at posedge+1; drives one instruction.
  task automatic issue_start(input logic [31:0] w);
    int n;
    int rd, rs1, rs2;
    logic [31:0] sx, a, b, v;
    logic [7:0] ad;
    n = 0;
    while (!inst_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("ready_timeout", 0, 1);
    rd  = int'(w[27:23]) % NR;
    rs1 = int'(w[22:18]) % NR;
    rs2 = int'(w[17:13]) % NR;
    sx  = {{16{w[15]}}, w[15:0]};
    a   = rf[rs1];
    b   = rf[rs2];
    ad  = eaddr(w);
    pc_old  = pc_new;
    res_old = res_new;
    rv_c  = -1;
    ill_c = -1;
    acc_c = cyc;
    pc_new = pc_old + 16'd1;
    v = 'x;
    case (w[31:28])
      4'd0: rdy_c = cyc + 3;
      4'd1: begin
        v = mm.exists(ad) ? mm[ad] : 'x;
        rv_c = cyc + 4; rdy_c = cyc + 5;
      end
      4'd2: begin
        mm[ad] = rf[rd];
        rdy_c = cyc + 4;
      end
      4'd3: begin
        if (rf[rd] == a) pc_new = pc_old + w[15:0];
        rdy_c = cyc + 3;
      end
      4'd4: v = a + b;
      4'd5: v = a - b;
      4'd6: v = a & b;
      4'd7: v = a | b;
      4'd8: v = a + sx;
      default: begin
        ill_c = cyc + 2; rdy_c = cyc + 3;
      end
    endcase
    if (w[31:28] >= 4 && w[31:28] <= 8) begin
      rv_c = cyc + 3; rdy_c = cyc + 4;
    end
    if (rv_c >= 0) begin
      res_new = v;
      if (rd != 0) rf[rd] = v;
    end
    inst = w;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    inst = $urandom;
  endtask

  task automatic wait_done();
    while (cyc < rdy_c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [31:0] w);
    issue_start(w);
    wait_done();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, {31'd0, inst_ready}, 0);
    check({tag, "_pc"}, {16'd0, pc}, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_rvalid"}, {31'd0, result_valid}, 0);
    check({tag, "_illegal"}, {31'd0, illegal}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] w, saved;
    logic [7:0]  ad;
    rst_n = 1'b0;
    inst = '0;
    inst_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'd0, inst_ready}, 1);
    chk = 1'b1;
    @(posedge clk); #1;

    run(ri(4'd8, 1, 0, 16'd5));
    check("addi5", result, 32'd5);
    run(ri(4'd8, 2, 0, 16'd7));
    check("addi7", result, 32'd7);
    run(rr(4'd4, 3, 1, 2));
    check("add12", result, 32'd12);
    run(ri(4'd2, 3, 0, 16'd10));
    check("sw_pc", {16'd0, pc}, 32'd4);
    run(ri(4'd3, 1, 1, 16'hFFFE));
    check("beq_taken", {16'd0, pc}, 32'd2);
    run(ri(4'd1, 4, 0, 16'd10));
    check("lw12", result, 32'd12);
    run(32'h0);
    run(ri(4'd3, 1, 2, 16'd9));
    check("beq_not", {16'd0, pc}, 32'd5);
    run(ri(4'd8, 0, 0, 16'd9));
    check("addi_r0", result, 32'd9);
    run(rr(4'd4, 5, 0, 0));
    check("add_r0", result, 32'd0);
    w = $urandom;
    w[31:28] = 4'd12;
    run(w);
    check("ill_pc", {16'd0, pc}, 32'd8);

    for (int k = 0; k < 200; k++) begin
      w = $urandom;
      w[31:28] = 4'($urandom_range(0, 15));
      if (w[31:28] == 4'd1) begin
        ad = eaddr(w);
        if (!mm.exists(ad)) w[31:28] = 4'd2;
      end
      run(w);
    end

    run(ri(4'd8, 6, 0, 16'h55));
    run(ri(4'd2, 6, 0, 16'd3));
    run(ri(4'd8, 7, 0, 16'h77));
    saved = mm[8'd3];
    issue_start(ri(4'd2, 7, 0, 16'd3));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", {31'd0, inst_ready}, 1);
    check("mid_rel_pc", {16'd0, pc}, 0);
    model_reset();
    mm[8'd3] = saved;
    chk = 1'b1;
    @(posedge clk); #1;
    check("mid_ready_1cyc", {31'd0, inst_ready}, 1);
    run(ri(4'd1, 8, 0, 16'd3));
    check("mem3_kept", result, 32'h55);
    run(rr(4'd4, 9, 6, 0));
    check("r6_cleared", result, 32'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
